// File: rtl/mpc_chan_adapter.sv
// Requester-side adapter for one multi-port-cache channel: in-order request FIFO,
// credit-limited load issue, response FIFO and a flush/drain handshake.
module mpc_chan_adapter #(
    parameter int unsigned REQ_DEPTH       = 4,
    parameter int unsigned RSP_DEPTH       = 4,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned ADDR_W          = 32,
    parameter int unsigned DATA_W          = 128
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 core_req_valid,
    output logic                                 core_req_ready,
    input  logic                                 core_req_op,
    input  logic [ADDR_W-1:0]                    core_req_addr,
    input  logic [DATA_W-1:0]                    core_req_wdata,
    output logic                                 chan_req_valid,
    input  logic                                 chan_req_ready,
    output logic                                 chan_req_op,
    output logic [ADDR_W-1:0]                    chan_req_addr,
    output logic [DATA_W-1:0]                    chan_req_wdata,
    input  logic                                 chan_rsp_valid,
    output logic                                 chan_rsp_ready,
    input  logic [DATA_W-1:0]                    chan_rsp_rdata,
    output logic                                 core_rsp_valid,
    input  logic                                 core_rsp_ready,
    output logic [DATA_W-1:0]                    core_rsp_rdata,
    input  logic                                 flush_req,
    output logic                                 flush_done,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
    output logic                                 rsp_err
);

    localparam int unsigned QPW = (REQ_DEPTH > 1) ? $clog2(REQ_DEPTH) : 1;
    localparam int unsigned QCW = $clog2(REQ_DEPTH + 1);
    localparam int unsigned RPW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int unsigned RCW = $clog2(RSP_DEPTH + 1);
    localparam int unsigned OW  = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [QPW-1:0] Q_LAST = QPW'(REQ_DEPTH - 1);
    localparam logic [QCW-1:0] Q_FULL = QCW'(REQ_DEPTH);
    localparam logic [RPW-1:0] R_LAST = RPW'(RSP_DEPTH - 1);
    localparam logic [OW-1:0]  O_MAX  = OW'(MAX_OUTSTANDING);
    localparam logic [RCW-1:0] C_INIT = RCW'(RSP_DEPTH);

    // HOLD is DONE after its pulse cycle, waiting for flush_req to fall
    typedef enum logic [1:0] {RUN, DRAIN, DONE, HOLD} state_t;
    state_t state, state_nxt;

    logic              q_op    [REQ_DEPTH];
    logic [ADDR_W-1:0] q_addr  [REQ_DEPTH];
    logic [DATA_W-1:0] q_wdata [REQ_DEPTH];
    logic [QPW-1:0]    q_wr, q_rd;
    logic [QCW-1:0]    q_cnt;

    logic [DATA_W-1:0] r_mem [RSP_DEPTH];
    logic [RPW-1:0]    r_wr, r_rd;
    logic [RCW-1:0]    r_cnt;

    logic [RCW-1:0]    credits;
    logic              err_q;

    logic req_empty, req_full, head_op, load_ok;
    logic push, fire, load_fire, rsp_in, rsp_ok, rsp_pop;

    assign req_empty = (q_cnt == '0);
    assign req_full  = (q_cnt == Q_FULL);
    assign head_op   = q_op[q_rd];
    assign load_ok   = (outstanding < O_MAX) && (credits != '0);
    assign push      = core_req_valid && core_req_ready;
    assign fire      = chan_req_valid && chan_req_ready;
    assign load_fire = fire && !head_op;
    assign rsp_in    = chan_rsp_valid && chan_rsp_ready;
    assign rsp_ok    = rsp_in && (outstanding != '0);
    assign rsp_pop   = core_rsp_valid && core_rsp_ready;
    assign rsp_err   = err_q;

    always_ff @(posedge clk) begin
        if (push) begin
            q_op[q_wr]    <= core_req_op;
            q_addr[q_wr]  <= core_req_addr;
            q_wdata[q_wr] <= core_req_wdata;
        end
        if (rsp_ok)
            r_mem[r_wr] <= chan_rsp_rdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_wr        <= '0;
            q_rd        <= '0;
            q_cnt       <= '0;
            r_wr        <= '0;
            r_rd        <= '0;
            r_cnt       <= '0;
            outstanding <= '0;
            credits     <= C_INIT;
            err_q       <= 1'b0;
        end else begin
            if (push) q_wr <= (q_wr == Q_LAST) ? '0 : q_wr + 1'b1;
            if (fire) q_rd <= (q_rd == Q_LAST) ? '0 : q_rd + 1'b1;
            case ({push, fire})
                2'b10:   q_cnt <= q_cnt + 1'b1;
                2'b01:   q_cnt <= q_cnt - 1'b1;
                default: ;
            endcase
            if (rsp_ok)  r_wr <= (r_wr == R_LAST) ? '0 : r_wr + 1'b1;
            if (rsp_pop) r_rd <= (r_rd == R_LAST) ? '0 : r_rd + 1'b1;
            case ({rsp_ok, rsp_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: ;
            endcase
            case ({load_fire, rsp_ok})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: ;
            endcase
            case ({load_fire, rsp_pop})
                2'b10:   credits <= credits - 1'b1;
                2'b01:   credits <= credits + 1'b1;
                default: ;
            endcase
            if (rsp_in && outstanding == '0)
                err_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= RUN;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:        if (flush_req) state_nxt = DRAIN;
            DRAIN:      if (req_empty && outstanding == '0) state_nxt = DONE;
            DONE, HOLD: state_nxt = flush_req ? HOLD : RUN;
            default:    state_nxt = RUN;
        endcase
    end

    // Handshake outputs are held low while rst is asserted, not just after the edge
    always_comb begin
        core_req_ready = !rst && (state == RUN) && !req_full;
        chan_req_valid = !rst && !req_empty && (head_op || load_ok);
        chan_req_op    = head_op;
        chan_req_addr  = q_addr[q_rd];
        chan_req_wdata = q_wdata[q_rd];
        chan_rsp_ready = !rst;
        core_rsp_valid = !rst && (r_cnt != '0);
        core_rsp_rdata = r_mem[r_rd];
        flush_done     = !rst && (state == DONE);
    end

endmodule

// File: tb/tb_mpc_chan_adapter.sv
// Self-checking bench for mpc_chan_adapter: directed scenarios plus randomized traffic
// checked against a queue-based reference model of the adapter's rules.
module tb_mpc_chan_adapter;

    localparam int REQ_DEPTH = 4;
    localparam int RSP_DEPTH = 4;
    localparam int MAX_OUT   = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         core_req_valid, core_req_ready, core_req_op;
    logic [31:0]  core_req_addr;
    logic [127:0] core_req_wdata;
    logic         chan_req_valid, chan_req_ready, chan_req_op;
    logic [31:0]  chan_req_addr;
    logic [127:0] chan_req_wdata;
    logic         chan_rsp_valid, chan_rsp_ready;
    logic [127:0] chan_rsp_rdata;
    logic         core_rsp_valid, core_rsp_ready;
    logic [127:0] core_rsp_rdata;
    logic         flush_req, flush_done;
    logic [2:0]   outstanding;
    logic         rsp_err;

    always #5 clk = ~clk;

    mpc_chan_adapter #(
        .REQ_DEPTH(REQ_DEPTH), .RSP_DEPTH(RSP_DEPTH), .MAX_OUTSTANDING(MAX_OUT),
        .ADDR_W(32), .DATA_W(128)
    ) dut (
        .clk(clk), .rst(rst),
        .core_req_valid(core_req_valid), .core_req_ready(core_req_ready),
        .core_req_op(core_req_op), .core_req_addr(core_req_addr), .core_req_wdata(core_req_wdata),
        .chan_req_valid(chan_req_valid), .chan_req_ready(chan_req_ready),
        .chan_req_op(chan_req_op), .chan_req_addr(chan_req_addr), .chan_req_wdata(chan_req_wdata),
        .chan_rsp_valid(chan_rsp_valid), .chan_rsp_ready(chan_rsp_ready), .chan_rsp_rdata(chan_rsp_rdata),
        .core_rsp_valid(core_rsp_valid), .core_rsp_ready(core_rsp_ready), .core_rsp_rdata(core_rsp_rdata),
        .flush_req(flush_req), .flush_done(flush_done), .outstanding(outstanding), .rsp_err(rsp_err)
    );

    typedef struct {
        logic         op;
        logic [31:0]  addr;
        logic [127:0] wdata;
    } req_t;

    // Reference model: pending requests, buffered responses, loads in flight.
    // Free credits are implied: RSP_DEPTH minus (in flight + buffered).
    req_t         mq[$];
    logic [127:0] rq[$];
    int           m_out;
    bit           m_err;
    int           ph;
    localparam int P_RUN = 0, P_DRAIN = 1, P_DONE = 2, P_WAIT = 3;

    int nvec = 0;
    int nerr = 0;

    function automatic bit e_req_ready();
        return !rst && ph == P_RUN && mq.size() < REQ_DEPTH;
    endfunction

    function automatic bit e_chan_valid();
        if (rst || mq.size() == 0) return 1'b0;
        return mq[0].op || (m_out < MAX_OUT && m_out + rq.size() < RSP_DEPTH);
    endfunction

    function automatic bit e_rsp_valid();
        return !rst && rq.size() > 0;
    endfunction

    function automatic bit e_flush_done();
        return !rst && ph == P_DONE;
    endfunction

    task automatic tick();
        bit push, fire, pop, rok, rbad;
        int nph;
        req_t r;
        push = core_req_valid && e_req_ready();
        fire = chan_req_ready && e_chan_valid();
        pop  = core_rsp_ready && e_rsp_valid();
        rok  = !rst && chan_rsp_valid && m_out > 0;
        rbad = !rst && chan_rsp_valid && m_out == 0;
        nph  = ph;
        case (ph)
            P_RUN:   if (flush_req) nph = P_DRAIN;
            P_DRAIN: if (mq.size() == 0 && m_out == 0) nph = P_DONE;
            default: nph = flush_req ? P_WAIT : P_RUN;
        endcase
        r.op = core_req_op; r.addr = core_req_addr; r.wdata = core_req_wdata;
        @(posedge clk);
        if (rst) begin
            mq.delete(); rq.delete(); m_out = 0; m_err = 1'b0; ph = P_RUN;
        end else begin
            if (fire) begin
                if (!mq[0].op) m_out++;
                void'(mq.pop_front());
            end
            if (rok) m_out--;
            if (rbad) m_err = 1'b1;
            if (pop) void'(rq.pop_front());
            if (rok) rq.push_back(chan_rsp_rdata);
            if (push) mq.push_back(r);
            ph = nph;
        end
        #1;
    endtask

    task automatic idle();
        core_req_valid = 0; core_req_op = 0; core_req_addr = '0; core_req_wdata = '0;
        chan_req_ready = 0; chan_rsp_valid = 0; chan_rsp_rdata = '0;
        core_rsp_ready = 0; flush_req = 0;
    endtask

    task automatic push(input logic op, input logic [31:0] a, input logic [127:0] d);
        core_req_valid = 1; core_req_op = op; core_req_addr = a; core_req_wdata = d;
        tick();
        core_req_valid = 0;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic settle();
        int n;
        n = 0;
        core_req_valid = 0; chan_req_ready = 1; core_rsp_ready = 1; flush_req = 0;
        while ((mq.size() > 0 || m_out > 0 || rq.size() > 0 || ph != P_RUN) && n < 100) begin
            chan_rsp_valid = (m_out > 0);
            chan_rsp_rdata = rnd128();
            tick();
            n++;
        end
        idle();
        #1;
        nvec++; if (n >= 100) begin nerr++; $display("FAIL settle_timeout: got %0d cycles, limit 100", n); end
        nvec++; if ({outstanding, core_rsp_valid, chan_req_valid} !== 5'b0)
            begin nerr++; $display("FAIL settle_idle: got out=%0d rspv=%b reqv=%b expected 0 0 0", outstanding, core_rsp_valid, chan_req_valid); end
    endtask

    task automatic test_reset();
        rst = 1; idle();
        tick(); tick();
        nvec++; if (core_req_ready !== 1'b0) begin nerr++; $display("FAIL rst_core_req_ready: got %b expected 0", core_req_ready); end
        nvec++; if (chan_req_valid !== 1'b0) begin nerr++; $display("FAIL rst_chan_req_valid: got %b expected 0", chan_req_valid); end
        nvec++; if (core_rsp_valid !== 1'b0) begin nerr++; $display("FAIL rst_core_rsp_valid: got %b expected 0", core_rsp_valid); end
        nvec++; if (flush_done !== 1'b0) begin nerr++; $display("FAIL rst_flush_done: got %b expected 0", flush_done); end
        nvec++; if (rsp_err !== 1'b0) begin nerr++; $display("FAIL rst_rsp_err: got %b expected 0", rsp_err); end
        nvec++; if (chan_rsp_ready !== 1'b0) begin nerr++; $display("FAIL rst_chan_rsp_ready: got %b expected 0", chan_rsp_ready); end
        nvec++; if (outstanding !== 3'd0) begin nerr++; $display("FAIL rst_outstanding: got %0d expected 0", outstanding); end
        rst = 0;
        #1;
        nvec++; if (core_req_ready !== 1'b1) begin nerr++; $display("FAIL run_core_req_ready: got %b expected 1", core_req_ready); end
        nvec++; if (chan_rsp_ready !== 1'b1) begin nerr++; $display("FAIL run_chan_rsp_ready: got %b expected 1", chan_rsp_ready); end
    endtask

    task automatic test_store_through();
        logic [127:0] wd;
        wd = 128'haaaa_bbbb_cccc_dddd;
        chan_req_ready = 1;
        core_req_valid = 1; core_req_op = 1; core_req_addr = 32'hA8; core_req_wdata = wd;
        #1;
        nvec++; if (chan_req_valid !== 1'b0) begin nerr++; $display("FAIL st_latency: got %b expected 0", chan_req_valid); end
        tick();
        core_req_valid = 0;
        #1;
        nvec++; if (chan_req_valid !== 1'b1) begin nerr++; $display("FAIL st_valid: got %b expected 1", chan_req_valid); end
        nvec++; if ({chan_req_op, chan_req_addr, chan_req_wdata} !== {1'b1, 32'hA8, wd})
            begin nerr++; $display("FAIL st_fields: got %b %h %h expected 1 a8 %h", chan_req_op, chan_req_addr, chan_req_wdata, wd); end
        tick();
        nvec++; if (chan_req_valid !== 1'b0) begin nerr++; $display("FAIL st_one_cycle: got %b expected 0", chan_req_valid); end
        nvec++; if (outstanding !== 3'd0) begin nerr++; $display("FAIL st_outstanding: got %0d expected 0", outstanding); end
        nvec++; if (core_rsp_valid !== 1'b0) begin nerr++; $display("FAIL st_no_rsp: got %b expected 0", core_rsp_valid); end
        settle();
    endtask

    task automatic test_credit_stall();
        int issued;
        issued = 0;
        core_rsp_ready = 0; chan_req_ready = 1; chan_rsp_valid = 0;
        for (int c = 0; c < 10; c++) begin
            core_req_valid = (c < 6);
            core_req_op = 0; core_req_addr = 32'h100 + 32'(c) * 16; core_req_wdata = rnd128();
            if (chan_req_valid === 1'b1) issued++;
            tick();
        end
        core_req_valid = 0;
        nvec++; if (issued !== 4) begin nerr++; $display("FAIL cs_issued: got %0d expected 4", issued); end
        nvec++; if (outstanding !== 3'd4) begin nerr++; $display("FAIL cs_outstanding: got %0d expected 4", outstanding); end
        nvec++; if (chan_req_valid !== e_chan_valid() || chan_req_valid !== 1'b0)
            begin nerr++; $display("FAIL cs_stalled: got %b expected 0", chan_req_valid); end
        for (int k = 1; k <= 4; k++) begin
            chan_rsp_valid = 1; chan_rsp_rdata = 128'(k);
            tick();
        end
        chan_rsp_valid = 0;
        #1;
        nvec++; if (outstanding !== 3'd0) begin nerr++; $display("FAIL cs_out_zero: got %0d expected 0", outstanding); end
        nvec++; if (chan_req_valid !== 1'b0) begin nerr++; $display("FAIL cs_no_credit: got %b expected 0", chan_req_valid); end
        nvec++; if (core_rsp_valid !== 1'b1 || core_rsp_rdata !== 128'h1)
            begin nerr++; $display("FAIL cs_rsp_head: got %b %h expected 1 1", core_rsp_valid, core_rsp_rdata); end
        core_rsp_ready = 1;
        tick();
        core_rsp_ready = 0;
        #1;
        nvec++; if (chan_req_valid !== 1'b1 || chan_req_addr !== 32'h140)
            begin nerr++; $display("FAIL cs_release: got %b %h expected 1 140", chan_req_valid, chan_req_addr); end
        nvec++; if (core_rsp_rdata !== 128'h2) begin nerr++; $display("FAIL cs_rsp_next: got %h expected 2", core_rsp_rdata); end
        settle();
    endtask

    task automatic test_backpressure();
        logic [160:0] held;
        chan_req_ready = 0;
        push(0, $urandom, rnd128());
        held = {chan_req_op, chan_req_addr, chan_req_wdata};
        nvec++; if (chan_req_valid !== 1'b1) begin nerr++; $display("FAIL bp_valid: got %b expected 1", chan_req_valid); end
        for (int c = 0; c < 5; c++) begin
            tick();
            nvec++; if (chan_req_valid !== 1'b1 || {chan_req_op, chan_req_addr, chan_req_wdata} !== {mq[0].op, mq[0].addr, mq[0].wdata}
                        || {chan_req_op, chan_req_addr, chan_req_wdata} !== held)
                begin nerr++; $display("FAIL bp_stable: got %b %h expected 1 %h", chan_req_valid, chan_req_addr, mq[0].addr); end
        end
        for (int c = 0; c < 4; c++) begin
            core_req_valid = 1; core_req_op = 1'($urandom); core_req_addr = $urandom; core_req_wdata = rnd128();
            #1;
            nvec++; if (core_req_ready !== e_req_ready()) begin nerr++; $display("FAIL bp_ready: got %b expected %b", core_req_ready, e_req_ready()); end
            tick();
        end
        core_req_valid = 0;
        #1;
        nvec++; if (core_req_ready !== 1'b0) begin nerr++; $display("FAIL bp_full: got %b expected 0", core_req_ready); end
        settle();
    endtask

    task automatic test_simultaneity();
        logic [127:0] x;
        x = rnd128();
        chan_req_ready = 0;
        for (int i = 0; i < 3; i++) push(0, 32'h200 + 32'(i) * 16, rnd128());
        chan_req_ready = 1;
        tick(); tick();
        chan_req_ready = 0;
        nvec++; if (outstanding !== 3'd2) begin nerr++; $display("FAIL sim_pre: got %0d expected 2", outstanding); end
        chan_req_ready = 1; chan_rsp_valid = 1; chan_rsp_rdata = x;
        #1;
        nvec++; if (chan_req_valid !== 1'b1) begin nerr++; $display("FAIL sim_fire: got %b expected 1", chan_req_valid); end
        tick();
        chan_req_ready = 0; chan_rsp_valid = 0;
        #1;
        nvec++; if (outstanding !== 3'd2) begin nerr++; $display("FAIL sim_out: got %0d expected 2", outstanding); end
        nvec++; if (core_rsp_valid !== 1'b1 || core_rsp_rdata !== x)
            begin nerr++; $display("FAIL sim_rsp: got %b %h expected 1 %h", core_rsp_valid, core_rsp_rdata, x); end
        settle();
    endtask

    task automatic test_flush();
        int pulses;
        pulses = 0;
        chan_req_ready = 0;
        push(0, 32'h300, rnd128());
        push(1, 32'h310, rnd128());
        push(0, 32'h320, rnd128());
        push(1, 32'h330, rnd128());
        chan_req_ready = 1;
        tick();
        chan_req_ready = 0;
        nvec++; if (outstanding !== 3'd1) begin nerr++; $display("FAIL fl_pre_out: got %0d expected 1", outstanding); end
        flush_req = 1;
        tick();
        nvec++; if (core_req_ready !== 1'b0) begin nerr++; $display("FAIL fl_drain_ready: got %b expected 0", core_req_ready); end
        for (int n = 0; n < 40; n++) begin
            chan_req_ready = 1; core_rsp_ready = 1;
            chan_rsp_valid = (m_out > 0) && (n % 2 == 1);
            chan_rsp_rdata = rnd128();
            #1;
            nvec++; if (flush_done !== e_flush_done()) begin nerr++; $display("FAIL fl_done: got %b expected %b", flush_done, e_flush_done()); end
            if (flush_done === 1'b1) pulses++;
            tick();
        end
        chan_rsp_valid = 0;
        nvec++; if (pulses !== 1) begin nerr++; $display("FAIL fl_pulses: got %0d expected 1", pulses); end
        nvec++; if (core_req_ready !== 1'b0) begin nerr++; $display("FAIL fl_hold_ready: got %b expected 0", core_req_ready); end
        flush_req = 0;
        tick();
        nvec++; if (core_req_ready !== 1'b1 || flush_done !== 1'b0)
            begin nerr++; $display("FAIL fl_back_run: got %b %b expected 1 0", core_req_ready, flush_done); end
        settle();
    endtask

    task automatic test_error_reset();
        chan_rsp_valid = 1; chan_rsp_rdata = rnd128();
        tick();
        chan_rsp_valid = 0;
        nvec++; if (rsp_err !== 1'b1) begin nerr++; $display("FAIL er_set: got %b expected 1", rsp_err); end
        nvec++; if (core_rsp_valid !== 1'b0) begin nerr++; $display("FAIL er_dropped: got %b expected 0", core_rsp_valid); end
        chan_req_ready = 1;
        for (int i = 0; i < 4; i++) begin
            chan_rsp_valid = (i > 1); chan_rsp_rdata = rnd128();
            push(0, $urandom, rnd128());
        end
        core_req_valid = 1;
        rst = 1;
        tick();
        nvec++; if ({core_req_ready, chan_req_valid, core_rsp_valid, flush_done, rsp_err, chan_rsp_ready, outstanding} !== 9'b0)
            begin nerr++; $display("FAIL er_rst_outputs: got %b%b%b%b%b%b %0d expected all 0", core_req_ready, chan_req_valid,
                                   core_rsp_valid, flush_done, rsp_err, chan_rsp_ready, outstanding); end
        rst = 0; idle();
        #1;
        nvec++; if ({core_req_ready, chan_req_valid, core_rsp_valid, rsp_err} !== 4'b1000)
            begin nerr++; $display("FAIL er_after_rst: got %b%b%b%b expected 1000", core_req_ready, chan_req_valid, core_rsp_valid, rsp_err); end
        chan_rsp_valid = 1;
        tick();
        chan_rsp_valid = 0;
        nvec++; if (rsp_err !== 1'b1) begin nerr++; $display("FAIL er_stale_rsp: got %b expected 1", rsp_err); end
    endtask

    task automatic test_random();
        rst = 1; idle(); tick(); rst = 0;
        for (int c = 0; c < 600; c++) begin
            core_req_valid = 1'($urandom_range(0, 1));
            core_req_op    = 1'($urandom_range(0, 1));
            core_req_addr  = $urandom;
            core_req_wdata = rnd128();
            chan_req_ready = ($urandom_range(0, 3) != 0);
            core_rsp_ready = ($urandom_range(0, 2) != 0);
            chan_rsp_valid = (m_out > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 59) == 0);
            chan_rsp_rdata = rnd128();
            if ($urandom_range(0, 29) == 0) flush_req = ~flush_req;
            #1;
            nvec++; if (core_req_ready !== e_req_ready()) begin nerr++; $display("FAIL rnd_core_req_ready c=%0d: got %b expected %b", c, core_req_ready, e_req_ready()); end
            nvec++; if (chan_req_valid !== e_chan_valid()) begin nerr++; $display("FAIL rnd_chan_req_valid c=%0d: got %b expected %b", c, chan_req_valid, e_chan_valid()); end
            if (mq.size() > 0) begin
                nvec++; if ({chan_req_op, chan_req_addr, chan_req_wdata} !== {mq[0].op, mq[0].addr, mq[0].wdata})
                    begin nerr++; $display("FAIL rnd_chan_req_head c=%0d: got %b %h expected %b %h", c, chan_req_op, chan_req_addr, mq[0].op, mq[0].addr); end
            end
            nvec++; if (core_rsp_valid !== e_rsp_valid()) begin nerr++; $display("FAIL rnd_core_rsp_valid c=%0d: got %b expected %b", c, core_rsp_valid, e_rsp_valid()); end
            if (rq.size() > 0) begin
                nvec++; if (core_rsp_rdata !== rq[0]) begin nerr++; $display("FAIL rnd_core_rsp_rdata c=%0d: got %h expected %h", c, core_rsp_rdata, rq[0]); end
            end
            nvec++; if (chan_rsp_ready !== 1'b1) begin nerr++; $display("FAIL rnd_chan_rsp_ready c=%0d: got %b expected 1", c, chan_rsp_ready); end
            nvec++; if (flush_done !== e_flush_done()) begin nerr++; $display("FAIL rnd_flush_done c=%0d: got %b expected %b", c, flush_done, e_flush_done()); end
            nvec++; if (outstanding !== 3'(m_out)) begin nerr++; $display("FAIL rnd_outstanding c=%0d: got %0d expected %0d", c, outstanding, m_out); end
            nvec++; if (rsp_err !== m_err) begin nerr++; $display("FAIL rnd_rsp_err c=%0d: got %b expected %b", c, rsp_err, m_err); end
            tick();
        end
        settle();
    endtask

    initial begin
        m_out = 0; m_err = 1'b0; ph = P_RUN;
        test_reset();
        test_store_through();
        test_credit_stall();
        test_backpressure();
        test_simultaneity();
        test_flush();
        test_error_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
